// File: rtl/decim_pkg.sv
// Shared constants, sample type and the clog2 helper for the decimator output path.
package decim_pkg;

  localparam int DECIM_DATA_W = 8;
  localparam int DECIM_LANES  = 4;

  typedef logic [DECIM_DATA_W-1:0] sample_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/decim_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on o_data while not empty.
module decim_sync_fifo
  import decim_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_data,
  output logic [clog2(DEPTH):0]       o_level,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/decim_packer.sv
// Packs strobed decimator samples into LANES-wide words and queues them on a valid/ready stream.
// Optional DECIM_PACKER_DROPCNT_EN adds a saturating 16-bit dropped-word counter output.
module decim_packer
  import decim_pkg::*;
#(
  parameter int DATA_W     = DECIM_DATA_W,
  parameter int LANES      = DECIM_LANES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          flush,
  output logic [DATA_W*LANES-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_partial,
  output logic [clog2(FIFO_DEPTH):0]    level,
`ifdef DECIM_PACKER_DROPCNT_EN
  output logic [15:0]                   drop_cnt,
`endif
  output logic                          overflow,
  input  logic                          ovf_clr
);

  // Stream handshake: the head word transfers on a rising edge where out_valid && out_ready;
  // out_data/out_partial stay stable while out_valid=1 and out_ready=0.

  localparam int LCW = clog2(LANES);
  localparam int WW  = DATA_W * LANES;

  logic [LCW-1:0] r_lane_cnt;
  logic [WW-1:0]  r_shift;
  logic           r_overflow;

  logic [WW-1:0]  w_word_next;
  logic           w_full_word;
  logic           w_flush_push;
  logic           w_push;
  logic           w_pop_ok;
  logic           w_drop;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [WW:0]    w_head;

  always_comb begin
    w_word_next = r_shift;
    for (int l = 0; l < LANES; l++) begin
      if (in_valid && (r_lane_cnt == LCW'(l))) w_word_next[l*DATA_W +: DATA_W] = in_data;
    end
  end

  // A sample arriving with flush is folded in first; a completed word makes the flush a no-op.
  assign w_full_word  = in_valid && (r_lane_cnt == LCW'(LANES - 1));
  assign w_flush_push = flush && !w_full_word && (in_valid || (r_lane_cnt != '0));
  assign w_push       = w_full_word || w_flush_push;
  assign w_pop_ok     = out_ready && !w_fifo_empty;
  assign w_drop       = w_push && w_fifo_full && !w_pop_ok;

  decim_sync_fifo #(
    .WIDTH (WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({w_flush_push, w_word_next}),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_level (level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign out_valid   = !w_fifo_empty;
  assign out_data    = w_head[WW-1:0];
  assign out_partial = w_head[WW];
  assign overflow    = r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane_cnt <= '0;
      r_shift    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_lane_cnt <= '0;
        r_shift    <= '0;
      end else if (in_valid) begin
        r_lane_cnt <= r_lane_cnt + LCW'(1);
        r_shift    <= w_word_next;
      end
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

`ifdef DECIM_PACKER_DROPCNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (ovf_clr)                    r_drop_cnt <= 16'd1;
      else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: doc/decim_packer.md
Name: decim_packer

Overview:
- Downstream stage of the moving-average decimator.
- Collects the sparse decimated samples, marked by a one-cycle valid strobe, and packs LANES samples into one wide word.
- Buffers the words in a small FIFO and presents them on a valid/ready stream to the bus/DMA side.
- The decimator cannot be back-pressured, so when the FIFO is full the block drops words and flags overflow instead of stalling.

Parameters:
- DATA_W, 8: sample width; must match the decimator output.
- LANES, 4: samples per output word; power of 2, at least 2.
- FIFO_DEPTH, 4: output FIFO depth in words; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  DATA_W  decimated sample from the decimator.
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle.
- flush  in  1  one-cycle pulse; emit any partially filled word, zero-padded.
- out_data  out  DATA_W*LANES  packed word; lane 0 in the LSBs.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head word when out_valid=1.
- out_partial  out  1  head word was produced by a flush with fewer than LANES samples.
- level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a word was dropped.
- ovf_clr  in  1  synchronous clear for overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - Lane counter, shift register and FIFO pointers go to 0.
  - out_valid=0, out_data=0, out_partial=0, level=0, overflow=0.
  - Reset asserted mid-word discards the partial word. Reset asserted mid-handshake discards the FIFO contents.
- Packing:
  - On each in_valid, in_data is written to lane[lane_cnt] and lane_cnt increments.
  - Sample order: the first sample goes to bits [DATA_W-1:0].
  - When the sample completing lane LANES-1 is captured, the assembled word (including that sample) is pushed in the same clock edge. lane_cnt wraps to 0 and the lane register is cleared to 0.
- Latency: out_valid rises one clock after the edge that captured the final lane, provided the FIFO was empty.
- Flush:
  - flush with lane_cnt>0: the word is pushed with unfilled lanes zero and out_partial=1 for that entry; lane_cnt returns to 0.
  - flush with lane_cnt=0: no action.
  - flush and in_valid in the same cycle: the sample is included first.
    - If that sample fills the word, one full word is pushed (out_partial=0) and the flush is a no-op.
    - Otherwise one partial word containing the sample is pushed.
- Output handshake:
  - A pop occurs when out_valid && out_ready.
  - out_data and out_partial hold stable while out_valid=1 and out_ready=0.
  - After a pop the next entry appears in the same cycle (FWFT). out_valid=0 when empty.
- FIFO full:
  - A push is accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle (level unchanged).
  - Otherwise the word is dropped, overflow is set, and lane_cnt still wraps to 0 (no stall, no corruption of the stored words).
- Pointers wrap modulo FIFO_DEPTH. level covers the range 0..FIFO_DEPTH.
- overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Clears on ovf_clr otherwise.
- Empty FIFO with pop attempted (out_ready=1, out_valid=0): no effect.

Optional Feature:
- Macro: DECIM_PACKER_DROPCNT_EN.
- When defined:
  - Adds output drop_cnt (16 bits): count of dropped words, saturating at 16'hFFFF.
  - drop_cnt is reset to 0 and cleared by ovf_clr unless a drop occurs in the same cycle (in which case it becomes 1).
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package decim_pkg holds:
  - DECIM_DATA_W=8 and DECIM_LANES=4 default constants.
  - The clog2 function.
  - Typedef sample_t (logic [DECIM_DATA_W-1:0]).
- Sub-module decim_sync_fifo: single-clock FWFT FIFO with parameters WIDTH and DEPTH, push/pop, level and full/empty.
  - Packer entry width is DATA_W*LANES+1 (the extra bit is out_partial).
- Packing, flush and overflow logic stay in decim_packer.

Test Plan:
- Reset, then in_valid with 0x11,0x22,0x33,0x44 (gaps of 63 cycles), out_ready=1 -> one word 0x44332211, out_valid one clock after the 4th strobe, out_partial=0.
- Samples 0xAA,0xBB then flush -> word 0x0000BBAA with out_partial=1. A second flush with lane_cnt=0 -> no word.
- in_valid=0x05 and flush in the same cycle after 0x01,0x02,0x03 -> single word 0x05030201, out_partial=0, level=1.
- out_ready=0, push 5 words (DEPTH=4) -> level=4, overflow=1, 5th word dropped. Drain -> the first four words are in order and unchanged.
- Full FIFO with a push and a pop in the same cycle -> level stays 4, overflow stays 0, new word appears last.
- reset asserted after 2 samples with 3 words queued -> out_valid=0, level=0 immediately. After release, 4 samples -> a clean word with no stale lanes. With DECIM_PACKER_DROPCNT_EN, drop_cnt returns to 0.
